// File: rtl/fle_pkg.sv
// fle_pkg: lifecycle states and configuration bit-index helpers for the fracturable logic element
package fle_pkg;
  typedef enum logic [1:0] {CFG, INIT, RUN} fle_state_t;
  function automatic int nbits(input int k);
    return (1 << k) + 4;
  endfunction
  function automatic int frac_bit(input int k);
    return 1 << k;
  endfunction
  function automatic int byp0_bit(input int k);
    return (1 << k) + 1;
  endfunction
  function automatic int byp1_bit(input int k);
    return (1 << k) + 2;
  endfunction
  function automatic int init_bit(input int k);
    return (1 << k) + 3;
  endfunction
endpackage

// File: rtl/fle_cfg_bank.sv
// fle_cfg_bank: bl/wl memory-bank configuration store; FLE_READBACK_EN adds a registered readback port
module fle_cfg_bank #(
  parameter int NBITS = 68
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [0:NBITS-1] bl,
  input  logic [0:NBITS-1] wl,
`ifdef FLE_READBACK_EN
  input  logic [$clog2(NBITS)-1:0] rb_addr,
  output logic                     rb_data,
`endif
  output logic [0:NBITS-1] cfg
);
  always_ff @(posedge clk)
    if (reset) cfg <= '0;
    else if (we) cfg <= (cfg & ~wl) | (bl & wl);
`ifdef FLE_READBACK_EN
  localparam int AW = $clog2(NBITS);
  // Compare one bit wider so NBITS that is an exact power of two stays representable
  logic in_range;
  assign in_range = {1'b0, rb_addr} < (AW + 1)'(NBITS);
  always_ff @(posedge clk)
    if (reset) rb_data <= 1'b0;
    else rb_data <= in_range ? cfg[rb_addr] : 1'b0;
`endif
endmodule

// File: rtl/fle_param_cfg.sv
// fle_param_cfg: K-input fracturable LE with config lifecycle FSM and two output FFs; FLE_READBACK_EN enables config readback
module fle_param_cfg
  import fle_pkg::*;
#(
  parameter int K = 6,
  localparam int NBITS = nbits(K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [0:K-1]     fle_in,
  input  logic             fle_en,
  input  logic [0:NBITS-1] bl,
  input  logic [0:NBITS-1] wl,
  input  logic             cfg_done,
`ifdef FLE_READBACK_EN
  input  logic [$clog2(NBITS)-1:0] rb_addr,
  output logic                     rb_data,
`endif
  output logic [0:1]       fle_out,
  output logic             cfg_ready
);
  localparam int LUTN = 1 << K;
  localparam int FRAC_B = frac_bit(K);
  localparam int BYP0_B = byp0_bit(K);
  localparam int BYP1_B = byp1_bit(K);
  localparam int INIT_B = init_bit(K);
  if (K < 2 || K > 8) begin : g_bad_k
    $error("fle_param_cfg: K must be in 2..8");
  end
  fle_state_t state;
  logic [0:NBITS-1] cfg;
  logic [0:LUTN-1] lut;
  logic [K-1:0] idx, idx_a, idx_b;
  logic comb_a, comb_b, ff_a, ff_b, run;
  fle_cfg_bank #(.NBITS(NBITS)) u_bank (
    .clk    (clk),
    .reset  (reset),
    .we     (state == CFG),
`ifdef FLE_READBACK_EN
    .rb_addr(rb_addr),
    .rb_data(rb_data),
`endif
    .bl     (bl),
    .wl     (wl),
    .cfg    (cfg)
  );
  assign lut = cfg[0:LUTN-1];
  always_comb begin
    idx = '0;
    for (int i = 0; i < K; i++) idx[i] = fle_in[i];
  end
  // Fractured mode splits the table into halves selected by the top index bit
  assign idx_a = cfg[FRAC_B] ? {1'b0, idx[K-2:0]} : idx;
  assign idx_b = {1'b1, idx[K-2:0]};
  assign comb_a = lut[idx_a];
  assign comb_b = cfg[FRAC_B] ? lut[idx_b] : comb_a;
  assign run = state == RUN;
  assign fle_out[0] = run & (cfg[BYP0_B] ? comb_a : ff_a);
  assign fle_out[1] = run & (cfg[BYP1_B] ? comb_b : ff_b);
  always_ff @(posedge clk)
    if (reset) begin
      state <= CFG;
      ff_a <= 1'b0;
      ff_b <= 1'b0;
      cfg_ready <= 1'b0;
    end else
      case (state)
        CFG: if (cfg_done) state <= INIT;
        INIT: begin
          state <= RUN;
          ff_a <= cfg[INIT_B];
          ff_b <= cfg[INIT_B];
          cfg_ready <= 1'b1;
        end
        RUN: if (fle_en) begin
          ff_a <= comb_a;
          ff_b <= comb_b;
        end
        default: state <= CFG;
      endcase
endmodule

// File: tb/tb_fle_param_cfg.sv
// tb_fle_param_cfg: directed self-checking bench for fle_param_cfg at K=6 (NBITS=68)
module tb_fle_param_cfg;
  localparam int K = 6;
  localparam int NB = 68;
  logic clk = 0;
  logic reset = 0;
  logic [0:K-1] fle_in = '0;
  logic fle_en = 0;
  logic [0:NB-1] bl = '0;
  logic [0:NB-1] wl = '0;
  logic cfg_done = 0;
  logic [0:1] fle_out;
  logic cfg_ready;
`ifdef FLE_READBACK_EN
  logic [6:0] rb_addr = '0;
  logic rb_data;
`endif
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  fle_param_cfg #(.K(K)) dut (
    .clk      (clk),
    .reset    (reset),
    .fle_in   (fle_in),
    .fle_en   (fle_en),
    .bl       (bl),
    .wl       (wl),
    .cfg_done (cfg_done),
`ifdef FLE_READBACK_EN
    .rb_addr  (rb_addr),
    .rb_data  (rb_data),
`endif
    .fle_out  (fle_out),
    .cfg_ready(cfg_ready)
  );
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // out2 packs so that bit 0 of the result is fle_out[0]
  function automatic logic [7:0] out2();
    return {6'b0, fle_out[1], fle_out[0]};
  endfunction
  task automatic do_reset();
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic write_all(input logic [0:NB-1] v);
    bl = v;
    wl = '1;
    tick();
    wl = '0;
    bl = '0;
  endtask
  task automatic commit();
    cfg_done = 1;
    tick();
    cfg_done = 0;
    tick();
  endtask
  logic [0:NB-1] v;
  initial begin
    do_reset();
    chk("rst_out", out2(), 8'd0);
    chk("rst_ready", {7'b0, cfg_ready}, 8'd0);
    // AND6, registered
    v = '0;
    v[63] = 1;
    write_all(v);
    cfg_done = 1;
    tick();
    cfg_done = 0;
    chk("init_ready", {7'b0, cfg_ready}, 8'd0);
    chk("init_out", out2(), 8'd0);
    tick();
    chk("run_ready", {7'b0, cfg_ready}, 8'd1);
    chk("run_out0", out2(), 8'd0);
    fle_in = '1;
    fle_en = 1;
    tick();
    chk("and6_hit", out2(), 8'd3);
    fle_in[0] = 0;
    tick();
    chk("and6_miss", out2(), 8'd0);
    fle_en = 0;
    fle_in = '1;
    tick();
    chk("en_hold", out2(), 8'd0);
    // Fracture, both outputs bypassed
    do_reset();
    v = '0;
    v[0] = 1;
    v[64] = 1;
    v[65] = 1;
    v[66] = 1;
    write_all(v);
    commit();
    fle_in = '0;
    #1;
    chk("frac_01", out2(), 8'd1);
    fle_in[5] = 1;
    #1;
    chk("frac_dc", out2(), 8'd1);
    fle_in = '0;
    fle_in[0] = 1;
    #1;
    chk("frac_idx1", out2(), 8'd0);
    do_reset();
    v[32] = 1;
    write_all(v);
    commit();
    fle_in = '0;
    #1;
    chk("frac_11", out2(), 8'd3);
    // Write-protect and commit ignored in RUN
    bl = '0;
    wl = '1;
    cfg_done = 1;
    tick();
    tick();
    wl = '0;
    cfg_done = 0;
    tick();
    chk("wp_out", out2(), 8'd3);
    chk("wp_ready", {7'b0, cfg_ready}, 8'd1);
    fle_in[5] = 1;
    #1;
    chk("wp_lut", out2(), 8'd3);
    // INIT value with no bypass, enable low
    do_reset();
    fle_en = 0;
    v = '0;
    v[67] = 1;
    write_all(v);
    cfg_done = 1;
    tick();
    cfg_done = 0;
    chk("initv_pre", out2(), 8'd0);
    tick();
    chk("initv_run", out2(), 8'd3);
    fle_in = '0;
    tick();
    tick();
    chk("initv_hold", out2(), 8'd3);
    // Write and commit in the same cycle
    do_reset();
    bl = '0;
    bl[63] = 1;
    wl = '0;
    wl[63] = 1;
    cfg_done = 1;
    tick();
    bl = '0;
    wl = '0;
    cfg_done = 0;
    tick();
    chk("sim_ready", {7'b0, cfg_ready}, 8'd1);
    fle_in = '1;
    fle_en = 1;
    tick();
    chk("sim_and6", out2(), 8'd3);
    fle_in[3] = 0;
    tick();
    chk("sim_miss", out2(), 8'd0);
    fle_in = '1;
    tick();
    chk("sim_hit2", out2(), 8'd3);
`ifdef FLE_READBACK_EN
    rb_addr = 7'd63;
    tick();
    chk("rb_63", {7'b0, rb_data}, 8'd1);
    rb_addr = 7'd100;
    tick();
    chk("rb_oor", {7'b0, rb_data}, 8'd0);
    rb_addr = 7'd63;
`endif
    // Reset mid-RUN
    do_reset();
    chk("mr_out", out2(), 8'd0);
    chk("mr_ready", {7'b0, cfg_ready}, 8'd0);
`ifdef FLE_READBACK_EN
    tick();
    chk("mr_rb63", {7'b0, rb_data}, 8'd0);
`endif
    commit();
    fle_in = '1;
    fle_en = 1;
    tick();
    chk("mr_cleared", out2(), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
